// File: rtl/arbiter_fifo2pipeout_pkg.sv
// Shared constants and FSM encoding for the FIFO-to-pipe-out readout arbiter.
// Used by the arbiter top and its output buffer.
package arbiter_fifo2pipeout_pkg;

    localparam int NUM_CORES   = 8;
    localparam int WORD_W      = 32;
    localparam int NUM_WORDS_W = 10;
    localparam int CORE_IDX_W  = $clog2(NUM_CORES);

    // One extra bit so the core index can reach NUM_CORES (scan finished)
    localparam int ADDR_W = CORE_IDX_W + 1;

    localparam logic [ADDR_W-1:0]      ADDR_END = ADDR_W'(NUM_CORES);
    localparam logic [ADDR_W-1:0]      ADDR_ONE = ADDR_W'(1);
    localparam logic [NUM_WORDS_W-1:0] WORD_ONE = NUM_WORDS_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        CHECK_ADDR = 2'b01,
        TRANSFER   = 2'b11
    } state_t;

endpackage

// File: rtl/arbiter_fifo2pipeout_fifo32_sync_fwft.sv
// Synchronous first-word-fall-through buffer of 32-bit words.
// The head output holds the last popped word while the buffer is empty.
module fifo32_sync_fwft
    import arbiter_fifo2pipeout_pkg::*;
#(
    parameter int FIFO_SIZE = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [WORD_W-1:0]          i_wr_data,
    input  logic                       i_rd_en,
    output logic [WORD_W-1:0]          o_rd_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(FIFO_SIZE):0] o_count
);

    localparam int AW = $clog2(FIFO_SIZE);
    localparam logic [AW:0]   CNT_FULL = FIFO_SIZE[AW:0];
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WORD_W-1:0] r_mem [FIFO_SIZE];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [WORD_W-1:0] r_last;
    logic              w_wr;
    logic              w_rd;
    logic              w_empty;
    logic              w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);
    // Full is judged on the pre-pop count, so a pop never frees a slot early
    assign w_wr    = i_wr_en && !w_full;
    assign w_rd    = i_rd_en && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = w_empty ? r_last : r_mem[r_rd_ptr];
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_count   = r_count;

endmodule

// File: rtl/arbiter_fifo2pipeout.sv
// Scans the selected cores in ascending order and moves num_words words
// from each core's output FIFO into a single host-facing buffer.
module arbiter_fifo2pipeout
    import arbiter_fifo2pipeout_pkg::*;
#(
    parameter int FIFO_SIZE = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CORES-1:0]          core_select,
    input  logic [NUM_WORDS_W-1:0]        num_words,
    output logic                          idle,
    output logic                          done,
    input  logic [NUM_CORES*WORD_W-1:0]   data_from_fifo,
    input  logic [NUM_CORES-1:0]          valid_from_fifo,
    output logic [NUM_CORES-1:0]          rd_en_2fifo,
    output logic [WORD_W-1:0]             pipe_out,
    input  logic                          pipe_out_read,
    output logic                          pipe_out_empty,
    output logic [$clog2(FIFO_SIZE):0]    pipe_out_count
);

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_addr_counter;
    logic [NUM_WORDS_W-1:0]  r_word_counter;
    logic [NUM_WORDS_W-1:0]  r_num_words;
    logic [NUM_CORES-1:0]    r_core_select;
    logic                    r_idle;
    logic                    r_done;

    logic [CORE_IDX_W-1:0]   w_core;
    logic                    w_full;
    logic                    w_push;
    logic [WORD_W-1:0]       w_wr_data;

    assign w_core = r_addr_counter[CORE_IDX_W-1:0];

    // rst gating keeps every core FIFO untouched while reset is held
    assign w_push = !rst
                 && (r_state == TRANSFER)
                 && valid_from_fifo[w_core]
                 && !w_full
                 && (r_word_counter != r_num_words);

    assign w_wr_data = data_from_fifo[w_core*WORD_W +: WORD_W];

    always_comb begin
        rd_en_2fifo         = '0;
        rd_en_2fifo[w_core] = w_push;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_addr_counter <= '0;
            r_word_counter <= '0;
            r_num_words    <= '0;
            r_core_select  <= '0;
            r_idle         <= 1'b1;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_core_select  <= core_select;
                        r_num_words    <= num_words;
                        r_addr_counter <= '0;
                        r_word_counter <= '0;
                        r_idle         <= 1'b0;
                        r_state        <= CHECK_ADDR;
                    end
                end
                CHECK_ADDR: begin
                    if (r_addr_counter >= ADDR_END) begin
                        r_done  <= 1'b1;
                        r_idle  <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_core_select[w_core]
                                 && (r_num_words != '0)) begin
                        r_state <= TRANSFER;
                    end else begin
                        r_addr_counter <= r_addr_counter + ADDR_ONE;
                    end
                end
                TRANSFER: begin
                    if (r_word_counter == r_num_words) begin
                        r_word_counter <= '0;
                        r_addr_counter <= r_addr_counter + ADDR_ONE;
                        r_state        <= CHECK_ADDR;
                    end else if (w_push) begin
                        r_word_counter <= r_word_counter + WORD_ONE;
                    end
                end
                default: begin
                    r_idle  <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign idle = r_idle;
    assign done = r_done;

    fifo32_sync_fwft #(
        .FIFO_SIZE (FIFO_SIZE)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_data),
        .i_rd_en   (pipe_out_read),
        .o_rd_data (pipe_out),
        .o_empty   (pipe_out_empty),
        .o_full    (w_full),
        .o_count   (pipe_out_count)
    );

endmodule

// File: tb/tb_arbiter_fifo2pipeout.sv
// Randomized bench for arbiter_fifo2pipeout with a word-stream reference
// model: selected cores in ascending order, num_words each.
module tb_arbiter_fifo2pipeout;

    localparam int FS = 4;
    localparam int CW = $clog2(FS) + 1;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    core_select;
    logic [9:0]    num_words;
    logic          idle;
    logic          done;
    logic [255:0]  data_from_fifo;
    logic [7:0]    valid_from_fifo;
    logic [7:0]    rd_en_2fifo;
    logic [31:0]   pipe_out;
    logic          pipe_out_read;
    logic          pipe_out_empty;
    logic [CW-1:0] pipe_out_count;

    arbiter_fifo2pipeout #(.FIFO_SIZE(FS)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .core_select    (core_select),
        .num_words      (num_words),
        .idle           (idle),
        .done           (done),
        .data_from_fifo (data_from_fifo),
        .valid_from_fifo(valid_from_fifo),
        .rd_en_2fifo    (rd_en_2fifo),
        .pipe_out       (pipe_out),
        .pipe_out_read  (pipe_out_read),
        .pipe_out_empty (pipe_out_empty),
        .pipe_out_count (pipe_out_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] core_data [8][DEPTH];
    int          idx [8];
    logic [31:0] exp_q [$];
    int          cnt_m;
    logic [31:0] last_m;
    logic [7:0]  cur_sel;
    int          cur_nw;
    int          done_seen;
    int          done_at;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // New core contents and the word stream the host should see
    task automatic prep(input logic [7:0] sel, input int nw);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            idx[i] = 0;
            for (int k = 0; k < DEPTH; k++) core_data[i][k] = $urandom;
        end
        for (int i = 0; i < 8; i++)
            if (sel[i])
                for (int k = 0; k < nw; k++) exp_q.push_back(core_data[i][k]);
        cur_sel   = sel;
        cur_nw    = nw;
        done_seen = 0;
        done_at   = -1;
    endtask

    // vmode: 0 all valid, 1 random, 2 alternate; rmode: 0 read, 1 random,
    // 2 low for 40 cycles then high, 3 always low
    task automatic cycle(input int vmode, input int rmode, input int c);
        logic pop;
        @(negedge clk);
        case (vmode)
            0:       valid_from_fifo = 8'hFF;
            1:       valid_from_fifo = 8'($urandom);
            default: valid_from_fifo = (c % 2 == 0) ? 8'hFF : 8'h00;
        endcase
        case (rmode)
            0:       pipe_out_read = 1'b1;
            1:       pipe_out_read = 1'($urandom);
            2:       pipe_out_read = (c >= 40);
            default: pipe_out_read = 1'b0;
        endcase
        if (c == 0) begin
            core_select = cur_sel;
            num_words   = 10'(cur_nw);
            start       = 1'b1;
        end else begin
            core_select = 8'($urandom);
            num_words   = 10'($urandom);
            start       = !idle && ($urandom_range(3) == 0);
        end
        for (int i = 0; i < 8; i++)
            data_from_fifo[i*32 +: 32] =
                core_data[i][(idx[i] < DEPTH) ? idx[i] : 0];
        #1;
        chk("count", pipe_out_count, cnt_m);
        chk("empty", pipe_out_empty, (cnt_m == 0));
        if (cnt_m == 0) chk("hold_last", pipe_out, last_m);
        if (rd_en_2fifo != 0) begin
            chk("rd_onehot", $onehot(rd_en_2fifo), 1);
            chk("rd_when_valid", (rd_en_2fifo & ~valid_from_fifo) == 0, 1);
            chk("rd_not_full", cnt_m < FS, 1);
        end
        for (int i = 0; i < 8; i++)
            if (rd_en_2fifo[i])
                chk("rd_excess", idx[i] < (cur_sel[i] ? cur_nw : 0), 1);
        if (rmode == 2 && c == 39) begin
            chk("stall_count", pipe_out_count, FS);
            chk("stall_rd_en", rd_en_2fifo, 0);
        end
        if (done) begin
            done_seen++;
            if (done_at < 0) done_at = c;
            chk("done_idle", idle, 1);
        end
        pop = pipe_out_read && (cnt_m > 0);
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("pop_extra", 1, 0);
            end else begin
                chk("data", pipe_out, exp_q[0]);
                last_m = exp_q.pop_front();
            end
        end
        for (int i = 0; i < 8; i++) if (rd_en_2fifo[i]) idx[i]++;
        cnt_m = cnt_m + ((rd_en_2fifo != 0) ? 1 : 0) - (pop ? 1 : 0);
    endtask

    task automatic run(input string name, input logic [7:0] sel,
                       input int nw, input int vmode, input int rmode);
        int c;
        int k;
        prep(sel, nw);
        k = (nw == 0) ? 0 : $countones(sel);
        c = 0;
        while (c < 3000 && !(done_seen > 0 && cnt_m == 0
                             && exp_q.size() == 0)) begin
            cycle(vmode, rmode, c);
            c++;
        end
        chk({name, ":done_once"}, done_seen, 1);
        if (vmode == 0 && rmode == 0)
            chk({name, ":done_latency"}, done_at, 10 + k * (nw + 1));
        for (int i = 0; i < 8; i++)
            chk({name, ":words"}, idx[i], sel[i] ? nw : 0);
        chk({name, ":drained"}, exp_q.size(), 0);
        chk({name, ":idle"}, idle, 1);
    endtask

    initial begin
        int c;
        rst             = 1'b1;
        start           = 1'b0;
        core_select     = '0;
        num_words       = '0;
        valid_from_fifo = '0;
        data_from_fifo  = '0;
        pipe_out_read   = 1'b0;
        cnt_m           = 0;
        last_m          = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idle", idle, 1);
        chk("rst_done", done, 0);
        chk("rst_empty", pipe_out_empty, 1);
        chk("rst_count", pipe_out_count, 0);
        chk("rst_pipe_out", pipe_out, 0);
        chk("rst_rd_en", rd_en_2fifo, 0);
        rst = 1'b0;

        run("two_cores", 8'h05, 3, 0, 0);
        run("none_sel", 8'h00, 5, 0, 0);
        run("zero_words", 8'hFF, 0, 0, 0);
        run("full_stall", 8'h80, 10, 0, 2);
        run("alt_valid", 8'h02, 5, 2, 0);

        // Reset after two of four words have left core 0
        prep(8'h01, 4);
        c = 0;
        while (c < 50 && idx[0] < 2) begin
            cycle(0, 3, c);
            c++;
        end
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        valid_from_fifo = 8'hFF;
        #1;
        chk("midrst_words", idx[0], 2);
        chk("midrst_rd_en", rd_en_2fifo, 0);
        @(posedge clk);
        #1;
        chk("midrst_rd_en_edge", rd_en_2fifo, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_empty", pipe_out_empty, 1);
        chk("midrst_count", pipe_out_count, 0);
        chk("midrst_pipe_out", pipe_out, 0);
        @(negedge clk);
        rst    = 1'b0;
        cnt_m  = 0;
        last_m = '0;
        exp_q.delete();
        run("after_rst", 8'h01, 2, 0, 0);

        for (int r = 0; r < 12; r++)
            run("random", 8'($urandom),
                ($urandom_range(4) == 0) ? 0 : int'($urandom_range(12, 1)),
                1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbiter_fifo2pipeout.md
ARBITER_FIFO2PIPEOUT -- requirements
Module: arbiter_fifo2pipeout

Interface
REQ-001 SHALL have parameter FIFO_SIZE, default 64: depth in 32-bit words of the internal output buffer; power of two, minimum 4.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins a readout.
REQ-005 SHALL have port core_select, input, 8: bit i set means core i is read.
REQ-006 SHALL have port num_words, input, 10: words to read from each selected core.
REQ-007 SHALL have port idle, output, 1: high when in IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when a readout completes.
REQ-009 SHALL have port data_from_fifo, input, 256: core i output-FIFO head word on bits [i*32 +: 32], FWFT.
REQ-010 SHALL have port valid_from_fifo, input, 8: core i head word is valid.
REQ-011 SHALL have port rd_en_2fifo, output, 8: pops the head of core i's output FIFO.
REQ-012 SHALL have port pipe_out, output, 32: output buffer head word, FWFT.
REQ-013 SHALL have port pipe_out_read, input, 1: host pops the buffer head.
REQ-014 SHALL have port pipe_out_empty, output, 1: the output buffer is empty.
REQ-015 SHALL have port pipe_out_count, output, clog2(FIFO_SIZE)+1: current buffer occupancy.

Function
REQ-016 SHALL use FSM states IDLE, CHECK_ADDR, TRANSFER; encodings 2'b00, 2'b01, 2'b11; any other value goes to IDLE next cycle.
REQ-017 In IDLE, start SHALL latch core_select and num_words into registers, clear addr_counter and word_counter, and go to CHECK_ADDR next cycle; start outside IDLE SHALL be ignored.
REQ-018 In CHECK_ADDR: if addr_counter >= 8, SHALL pulse done and go to IDLE; else if the latched select bit for addr_counter is set and latched num_words != 0, SHALL go to TRANSFER; otherwise SHALL increment addr_counter and stay in CHECK_ADDR. Each CHECK_ADDR visit costs one cycle.
REQ-019 In TRANSFER, push = valid_from_fifo[addr_counter] AND buffer not full AND word_counter != latched num_words.
REQ-020 rd_en_2fifo[addr_counter] SHALL equal push; all other rd_en_2fifo bits SHALL be 0; push writes data_from_fifo[addr_counter*32 +: 32] into the buffer in the same cycle.
REQ-021 Each push SHALL increment word_counter. When word_counter equals latched num_words, the FSM SHALL clear word_counter, increment addr_counter, and return to CHECK_ADDR.
REQ-022 rd_en_2fifo SHALL be all zero outside TRANSFER.
REQ-023 The buffer SHALL pop when pipe_out_read is high and it is not empty; pipe_out_read while empty SHALL be ignored.
REQ-024 A simultaneous push and pop SHALL leave the count unchanged; "full" SHALL be evaluated on the pre-pop count, so there is no push when count == FIFO_SIZE even if a pop occurs that cycle.
REQ-025 When empty, pipe_out SHALL hold its last value.
REQ-026 Read pointers SHALL wrap modulo FIFO_SIZE.
REQ-027 Changes to core_select or num_words during a readout SHALL NOT affect that readout.

Reset
REQ-028 On rst, the FSM SHALL go to IDLE; counters, latched registers and buffer pointers SHALL go to 0; rd_en_2fifo=0, done=0, idle=1, pipe_out_empty=1, pipe_out_count=0, pipe_out=0.
REQ-029 rst asserted mid-transfer SHALL discard buffered data, and no rd_en_2fifo SHALL be asserted while rst is high.

Structure
REQ-030 A shared package SHALL hold NUM_CORES=8, WORD_W=32, NUM_WORDS_W=10 and the state encodings.
REQ-031 The output buffer SHALL be one sub-module, fifo32_sync_fwft, parameterised by FIFO_SIZE; the FSM and counters stay in the top module.

Verification
REQ-032 core_select=8'h05, num_words=3, all cores valid, pipe_out_read held high -> pipe_out emits core0 words 0..2 then core2 words 0..2; done pulses once; 6 rd_en pulses total.
REQ-033 core_select=8'h00 -> done exactly 9 cycles after start (8 CHECK_ADDR skips plus the exit check); no rd_en asserted.
REQ-034 FIFO_SIZE=4, core_select=8'h80, num_words=10, pipe_out_read low -> pipe_out_count stops at 4 and rd_en_2fifo[7] goes low; enabling reads then drains all 10 words in order.
REQ-035 valid_from_fifo[1] toggling every other cycle, core_select=8'h02, num_words=5 -> rd_en_2fifo[1] is high only on valid cycles and exactly 5 words are transferred.
REQ-036 rst asserted after 2 of 4 words with core_select=8'h01 -> idle=1, pipe_out_empty=1, count=0 on the next edge; a new start with num_words=2 reads cleanly.
REQ-037 num_words=0, core_select=8'hFF -> no transfer, and done is reached without entering TRANSFER.
